// File: rtl/dmem_ctrl.sv
// dmem_ctrl: latency-configurable byte/half/word data-memory controller with valid/ready requests.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of forcing LSBs.
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic we_q, sgn_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic oor, mis, err, access;
  logic [1:0] lane;
  logic [3:0] be;
  logic [31:0] rd, sh, wsh, load;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  always_comb begin
    idx    = addr_q[IW+1:2];
    oor    = (addr_q >> (IW + 2)) != '0;
    mis    = size_q == 2'b01 ? addr_q[0] : size_q == 2'b10 ? |addr_q[1:0] : 1'b0;
`ifdef MISALIGN_TRAP_EN
    err    = oor | (size_q == 2'b11) | mis;
`else
    err    = oor | (size_q == 2'b11);
`endif
    // Half/word lanes ignore the low address bits they cannot use.
    lane   = size_q == 2'b10 ? 2'b00 : size_q == 2'b01 ? {addr_q[1], 1'b0} : addr_q[1:0];
    be     = size_q == 2'b00 ? 4'b0001 << lane : size_q == 2'b01 ? 4'b0011 << lane : 4'b1111;
    wsh    = wdata_q << {lane, 3'b000};
    rd     = mem[idx];
    sh     = rd >> {lane, 3'b000};
    load   = size_q == 2'b00 ? {{24{sgn_q & sh[7]}}, sh[7:0]} :
             size_q == 2'b01 ? {{16{sgn_q & sh[15]}}, sh[15:0]} : rd;
    access = state == BUSY && cnt == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          sgn_q   <= req_signed;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt     <= 4'(LATENCY - 1);
          state   <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err | we_q) ? '0 : load;
        end else cnt <= cnt - 4'd1;
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  // Storage is never reset; writes only happen on a legal store's access edge.
  always_ff @(posedge clk)
    if (access && we_q && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl with LATENCY=1 and LATENCY=4 instances sharing stimulus.
module tb_dmem_ctrl;
  logic clk = 0, rst_n;
  logic req_valid = 0, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic ready1, rv1, err1, busy1, ready4, rv4, err4, busy4;
  logic [31:0] rd1, rd4;
  logic [31:0] r1, r4;
  logic e1, e4;
  int l1, l4;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(16), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1), .busy(busy1));
  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(16), .LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready4), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(err4), .busy(busy4));
  task automatic txn(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    logic got1, got4;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    got1 = 0; got4 = 0;
    for (int k = 1; k <= 30 && !(got1 && got4); k++) begin
      @(negedge clk);
      if (rv1 && !got1) begin got1 = 1; r1 = rd1; e1 = err1; l1 = k; end
      if (rv4 && !got4) begin got4 = 1; r4 = rd4; e4 = err4; l4 = k; end
    end
    if (!(got1 && got4)) begin
      checks++; failures++;
      $display("FAIL txn_timeout addr=%h got1=%b got4=%b", a, got1, got4);
    end
  endtask
  task automatic test_reset;
    checks++; if ({ready1, rv1, err1, busy1, rd1} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin failures++; $display("FAIL reset_u1 got=%b%b%b%b %h", ready1, rv1, err1, busy1, rd1); end
    checks++; if ({ready4, rv4, err4, busy4, rd4} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin failures++; $display("FAIL reset_u4 got=%b%b%b%b %h", ready4, rv4, err4, busy4, rd4); end
  endtask
  task automatic test_word;
    txn(1, 2'b10, 0, 32'h0C, 32'hDEADBEEF);
    checks++; if (e1 !== 1'b0 || r1 !== 32'h0) begin failures++; $display("FAIL sw_rsp got err=%b rdata=%h want 0 0", e1, r1); end
    checks++; if (l1 !== 2) begin failures++; $display("FAIL lat1 got=%0d want=2", l1); end
    checks++; if (l4 !== 5) begin failures++; $display("FAIL lat4 got=%0d want=5", l4); end
    txn(0, 2'b10, 0, 32'h0C, 32'h0);
    checks++; if (r1 !== 32'hDEADBEEF || e1 !== 1'b0) begin failures++; $display("FAIL lw_u1 got=%h err=%b want=deadbeef", r1, e1); end
    checks++; if (r4 !== 32'hDEADBEEF || e4 !== 1'b0) begin failures++; $display("FAIL lw_u4 got=%h err=%b want=deadbeef", r4, e4); end
  endtask
  task automatic test_bytes;
    txn(1, 2'b10, 0, 32'h10, 32'h0);
    txn(1, 2'b00, 0, 32'h12, 32'hF0);
    txn(0, 2'b10, 0, 32'h10, 32'h0);
    checks++; if (r1 !== 32'h00F00000 || r4 !== 32'h00F00000) begin failures++; $display("FAIL sb_lw got=%h/%h want=00f00000", r1, r4); end
    txn(0, 2'b00, 1, 32'h12, 32'h0);
    checks++; if (r1 !== 32'hFFFFFFF0 || r4 !== 32'hFFFFFFF0) begin failures++; $display("FAIL lb got=%h/%h want=fffffff0", r1, r4); end
    txn(0, 2'b00, 0, 32'h12, 32'h0);
    checks++; if (r1 !== 32'h000000F0 || r4 !== 32'h000000F0) begin failures++; $display("FAIL lbu got=%h/%h want=000000f0", r1, r4); end
  endtask
  task automatic test_half;
    txn(1, 2'b10, 0, 32'h20, 32'hAAAA5555);
    txn(1, 2'b01, 0, 32'h20, 32'h00008001);
    txn(0, 2'b01, 1, 32'h20, 32'h0);
    checks++; if (r1 !== 32'hFFFF8001 || r4 !== 32'hFFFF8001) begin failures++; $display("FAIL lh got=%h/%h want=ffff8001", r1, r4); end
    txn(0, 2'b01, 0, 32'h20, 32'h0);
    checks++; if (r1 !== 32'h00008001 || r4 !== 32'h00008001) begin failures++; $display("FAIL lhu got=%h/%h want=00008001", r1, r4); end
    txn(0, 2'b10, 0, 32'h20, 32'h0);
    checks++; if (r1 !== 32'hAAAA8001 || r4 !== 32'hAAAA8001) begin failures++; $display("FAIL sh_lw got=%h/%h want=aaaa8001", r1, r4); end
  endtask
  task automatic test_back_to_back;
    logic [12:1] rdy, rsp, rdy_exp, rsp_exp;
    logic [31:0] dat;
    dat = 0;
    @(negedge clk);
    req_we = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h0C; req_valid = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      rdy[k] = ready4; rsp[k] = rv4;
      if (rv4) dat = rd4;
      rdy_exp[k] = (k % 6) == 0;
      rsp_exp[k] = (k % 6) == 5;
    end
    req_valid = 0;
    checks++; if (rdy !== rdy_exp) begin failures++; $display("FAIL b2b_ready got=%b want=%b", rdy, rdy_exp); end
    checks++; if (rsp !== rsp_exp) begin failures++; $display("FAIL b2b_rsp got=%b want=%b", rsp, rsp_exp); end
    checks++; if (dat !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_data got=%h want=deadbeef", dat); end
    repeat (10) @(negedge clk);
  endtask
  task automatic test_errors;
    txn(0, 2'b10, 0, 32'd64, 32'h0);
    checks++; if ({e1, e4, r1, r4} !== {2'b11, 64'h0}) begin failures++; $display("FAIL oor got err=%b%b rdata=%h/%h want err=11 rdata=0", e1, e4, r1, r4); end
    txn(0, 2'b10, 0, 32'h8000_000C, 32'h0);
    checks++; if ({e1, e4} !== 2'b11) begin failures++; $display("FAIL oor_hi got=%b%b want=11", e1, e4); end
    txn(0, 2'b11, 0, 32'h0C, 32'h0);
    checks++; if ({e1, e4, r1} !== {2'b11, 32'h0}) begin failures++; $display("FAIL size11 got err=%b%b rdata=%h want 11 0", e1, e4, r1); end
    txn(1, 2'b10, 0, 32'h00, 32'h55667788);
    txn(1, 2'b10, 0, 32'h02, 32'h11223344);
`ifdef MISALIGN_TRAP_EN
    checks++; if ({e1, e4} !== 2'b11) begin failures++; $display("FAIL mis_err got=%b%b want=11", e1, e4); end
    txn(0, 2'b10, 0, 32'h00, 32'h0);
    checks++; if (r1 !== 32'h55667788 || r4 !== 32'h55667788) begin failures++; $display("FAIL mis_word got=%h/%h want=55667788", r1, r4); end
`else
    checks++; if ({e1, e4} !== 2'b00) begin failures++; $display("FAIL mis_err got=%b%b want=00", e1, e4); end
    txn(0, 2'b10, 0, 32'h00, 32'h0);
    checks++; if (r1 !== 32'h11223344 || r4 !== 32'h11223344) begin failures++; $display("FAIL mis_word got=%h/%h want=11223344", r1, r4); end
`endif
  endtask
  task automatic test_reset_mid;
    logic seen;
    seen = 0;
    txn(1, 2'b10, 0, 32'h30, 32'h0BADBEEF);
    @(negedge clk);
    req_we = 1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rv4) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_rsp got=%b want=0", seen); end
    checks++; if ({busy4, ready4} !== 2'b01) begin failures++; $display("FAIL rst_mid_state busy=%b ready=%b want 0 1", busy4, ready4); end
    txn(0, 2'b10, 0, 32'h30, 32'h0);
    checks++; if (r4 !== 32'h0BADBEEF) begin failures++; $display("FAIL rst_mid_mem got=%h want=0badbeef", r4); end
  endtask
  initial begin
    rst_n = 1;
    #2 rst_n = 0;
    #1 test_reset;
    repeat (2) @(negedge clk);
    rst_n = 1;
    test_word;
    test_bytes;
    test_half;
    test_back_to_back;
    test_errors;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
